// File: rtl/regfile_fwd_pipe_pkg.sv
// Shared defaults and the width-independent part of the writeback-tracking slot record.
package regfile_fwd_pipe_pkg;

    localparam int unsigned DSIZE_DEF    = 64;
    localparam int unsigned ASIZE_DEF    = 5;
    localparam int unsigned ZERO_REG_DEF = 31;

    // Control flags of one post-ID slot; the top adds waddr and data at its own widths.
    typedef struct packed {
        logic valid;
        logic wen;
        logic is_load;
        logic rdy;
    } slot_ctl_t;

endpackage

// File: rtl/regfile_array.sv
// Register storage: 2^ASIZE x DSIZE, NREAD asynchronous read ports, one synchronous write port.
module regfile_array #(
    parameter int unsigned DSIZE = 64,
    parameter int unsigned ASIZE = 5,
    parameter int unsigned NREAD = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [ASIZE-1:0]       waddr_i,
    input  logic [DSIZE-1:0]       wdata_i,
    input  logic [NREAD*ASIZE-1:0] raddr_i,
    output logic [NREAD*DSIZE-1:0] rdata_o
);

    localparam int unsigned NREGS = 2 ** ASIZE;

    logic [DSIZE-1:0] mem_q [NREGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NREAD; p++) begin
            rdata_o[p*DSIZE +: DSIZE] = mem_q[raddr_i[p*ASIZE +: ASIZE]];
        end
    end

endmodule

// File: rtl/regfile_fwd_pipe.sv
// Register file with in-flight writeback tracking, result forwarding to ID reads
// and an ID-stage interlock when a needed result is not ready yet.
module regfile_fwd_pipe
    import regfile_fwd_pipe_pkg::*;
#(
    parameter int unsigned DSIZE      = DSIZE_DEF,
    parameter int unsigned ASIZE      = ASIZE_DEF,
    parameter int unsigned NREAD      = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned ZERO_REG   = ZERO_REG_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NREAD-1:0]       id_ren,
    input  logic [NREAD*ASIZE-1:0] id_raddr,
    input  logic                   id_wen,
    input  logic [ASIZE-1:0]       id_waddr,
    input  logic                   id_is_load,
    input  logic [DSIZE-1:0]       alu_result,
    input  logic [DSIZE-1:0]       load_result,
    output logic [NREAD*DSIZE-1:0] rdata,
    output logic [NREAD-1:0]       fwd_hit,
    output logic                   stall,
    output logic                   wb_wen,
    output logic [ASIZE-1:0]       wb_waddr,
    output logic [DSIZE-1:0]       wb_wdata
);

    if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
        $error("regfile_fwd_pipe: DEPTH must be in 2..8");
    end
    if (LOAD_STAGE < 1 || LOAD_STAGE > DEPTH - 1) begin : g_bad_load_stage
        $error("regfile_fwd_pipe: LOAD_STAGE must be in 1..DEPTH-1");
    end
    if (ZERO_REG >= 2 ** ASIZE) begin : g_bad_zero_reg
        $error("regfile_fwd_pipe: ZERO_REG must fit in ASIZE bits");
    end
    if (NREAD < 1 || ASIZE < 1 || DSIZE < 1) begin : g_bad_width
        $error("regfile_fwd_pipe: NREAD, ASIZE and DSIZE must be nonzero");
    end

    localparam logic [ASIZE-1:0] ZREG = ASIZE'(ZERO_REG);

    typedef struct packed {
        slot_ctl_t        ctl;
        logic [ASIZE-1:0] waddr;
        logic [DSIZE-1:0] data;
    } slot_t;

    slot_t slot_q [1:DEPTH];
    slot_t slot_d [1:DEPTH];

    logic [NREAD*DSIZE-1:0] arr_rdata;
    logic [NREAD-1:0]       hazard;

    regfile_array #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE),
        .NREAD(NREAD)
    ) u_regfile_array (
        .clk_i  (clk),
        .rst_i  (rst),
        .we_i   (wb_wen),
        .waddr_i(wb_waddr),
        .wdata_i(wb_wdata),
        .raddr_i(id_raddr),
        .rdata_o(arr_rdata)
    );

    // Youngest matching slot wins; the slot-DEPTH match also covers same-cycle commit.
    always_comb begin
        logic             found;
        logic [ASIZE-1:0] ra;
        rdata   = arr_rdata;
        fwd_hit = '0;
        hazard  = '0;
        for (int p = 0; p < NREAD; p++) begin
            found = 1'b0;
            ra    = id_raddr[p*ASIZE +: ASIZE];
            if (id_ren[p]) begin
                if (ra == ZREG) begin
                    rdata[p*DSIZE +: DSIZE] = '0;
                end else begin
                    for (int s = 1; s <= DEPTH; s++) begin
                        if (!found && slot_q[s].ctl.valid && slot_q[s].ctl.wen &&
                            slot_q[s].waddr == ra) begin
                            found = 1'b1;
                            if (slot_q[s].ctl.rdy) begin
                                rdata[p*DSIZE +: DSIZE] = slot_q[s].data;
                                fwd_hit[p]              = 1'b1;
                            end else begin
                                hazard[p] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign stall = id_valid & (|hazard);

    always_comb begin
        slot_d[1] = '0;
        if (id_valid && !stall) begin
            slot_d[1].ctl.valid   = 1'b1;
            slot_d[1].ctl.wen     = id_wen;
            slot_d[1].ctl.is_load = id_is_load;
            slot_d[1].waddr       = id_waddr;
        end
        for (int s = 2; s <= DEPTH; s++) begin
            slot_d[s] = slot_q[s-1];
            if (slot_q[s-1].ctl.valid) begin
                if (s == 2 && !slot_q[s-1].ctl.is_load) begin
                    slot_d[s].data    = alu_result;
                    slot_d[s].ctl.rdy = 1'b1;
                end
                if (s - 1 == int'(LOAD_STAGE) && slot_q[s-1].ctl.is_load) begin
                    slot_d[s].data    = load_result;
                    slot_d[s].ctl.rdy = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 1; s <= DEPTH; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            for (int s = 1; s <= DEPTH; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

    assign wb_wen   = slot_q[DEPTH].ctl.valid & slot_q[DEPTH].ctl.wen &
                      (slot_q[DEPTH].waddr != ZREG);
    assign wb_waddr = slot_q[DEPTH].waddr;
    assign wb_wdata = slot_q[DEPTH].data;

endmodule

// File: tb/tb_regfile_fwd_pipe.sv
// Directed bench for regfile_fwd_pipe with a scoreboard of expected read results.
module tb_regfile_fwd_pipe;

    localparam int DSIZE = 64;
    localparam int ASIZE = 5;
    localparam int NREAD = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   id_valid = 1'b0;
    logic [NREAD-1:0]       id_ren = '0;
    logic [NREAD*ASIZE-1:0] id_raddr = '0;
    logic                   id_wen = 1'b0;
    logic [ASIZE-1:0]       id_waddr = '0;
    logic                   id_is_load = 1'b0;
    logic [DSIZE-1:0]       alu_result = '0;
    logic [DSIZE-1:0]       load_result = '0;
    logic [NREAD*DSIZE-1:0] rdata;
    logic [NREAD-1:0]       fwd_hit;
    logic                   stall;
    logic                   wb_wen;
    logic [ASIZE-1:0]       wb_waddr;
    logic [DSIZE-1:0]       wb_wdata;

    regfile_fwd_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_ren     (id_ren),
        .id_raddr   (id_raddr),
        .id_wen     (id_wen),
        .id_waddr   (id_waddr),
        .id_is_load (id_is_load),
        .alu_result (alu_result),
        .load_result(load_result),
        .rdata      (rdata),
        .fwd_hit    (fwd_hit),
        .stall      (stall),
        .wb_wen     (wb_wen),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] r0;
        logic [63:0] r1;
        logic [1:0]  hit;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        id_ren   = '0;
        id_wen   = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [4:0] wa, input logic ld);
        id_valid   = 1'b1;
        id_ren     = '0;
        id_wen     = 1'b1;
        id_waddr   = wa;
        id_is_load = ld;
        cyc();
        id_valid   = 1'b0;
        id_wen     = 1'b0;
        id_is_load = 1'b0;
    endtask

    // Issue one read instruction, hold it through any interlock, then score it.
    task automatic rd(input string tag, input logic [1:0] ren, input logic [4:0] a0,
                      input logic [4:0] a1, input logic [63:0] e0, input logic [63:0] e1,
                      input logic [1:0] ehit, input int estall);
        exp_t e;
        int   stalls = 0;
        e.r0 = e0;
        e.r1 = e1;
        e.hit = ehit;
        e.stalls = estall;
        sb.push_back(e);
        id_valid   = 1'b1;
        id_wen     = 1'b0;
        id_is_load = 1'b0;
        id_ren     = ren;
        id_raddr   = {a1, a0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            cyc();
        end
        e = sb.pop_front();
        chk({tag, " stalls"}, 64'(stalls), 64'(e.stalls));
        chk({tag, " rdata0"}, rdata[63:0], e.r0);
        chk({tag, " rdata1"}, rdata[127:64], e.r1);
        chk({tag, " fwd_hit"}, 64'(fwd_hit), 64'(e.hit));
        cyc();
        id_valid = 1'b0;
        id_ren   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset wb_wen", 64'(wb_wen), 64'd0);
        chk("reset fwd_hit", 64'(fwd_hit), 64'd0);
        rst = 1'b0;
        cyc();

        rd("t1", 2'b11, 5'd1, 5'd2, 64'd0, 64'd0, 2'b00, 0);

        // ALU-use: one stall, then forward; commit two cycles after slot 1.
        wr(5'd3, 1'b0);
        alu_result = 64'h1234;
        rd("t2", 2'b01, 5'd3, 5'd0, 64'h1234, 64'd0, 2'b01, 1);
        @(negedge clk);
        chk("t2 wb_wen", 64'(wb_wen), 64'd1);
        chk("t2 wb_waddr", 64'(wb_waddr), 64'd3);
        chk("t2 wb_wdata", wb_wdata, 64'h1234);
        cyc();
        rd("t2 array", 2'b01, 5'd3, 5'd0, 64'h1234, 64'd0, 2'b00, 0);

        // Load-use: two stalls; alu_result is a decoy.
        alu_result  = 64'hBAD;
        load_result = 64'hDEAD;
        wr(5'd5, 1'b1);
        rd("t3", 2'b11, 5'd5, 5'd3, 64'hDEAD, 64'h1234, 2'b01, 2);

        // Two writes to X7: the younger one must win.
        alu_result = 64'h0;
        wr(5'd7, 1'b0);
        alu_result = 64'h11;
        wr(5'd7, 1'b0);
        alu_result = 64'h22;
        rd("t4", 2'b10, 5'd0, 5'd7, 64'd0, 64'h22, 2'b10, 1);
        idle(3);
        rd("t4 array", 2'b11, 5'd7, 5'd5, 64'h22, 64'hDEAD, 2'b00, 0);

        // XZR writes never commit and XZR reads are zero.
        alu_result = 64'hFF;
        wr(5'd31, 1'b0);
        rd("t5", 2'b11, 5'd31, 5'd31, 64'd0, 64'd0, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5 wb_wen", 64'(wb_wen), 64'd0);
            cyc();
        end

        // A disabled port never interlocks, even on a pending load.
        load_result = 64'hBEEF;
        wr(5'd9, 1'b1);
        rd("t5 ren0", 2'b00, 5'd9, 5'd9, 64'd0, 64'd0, 2'b00, 0);
        idle(3);

        // Reset in flight with a pending load to X9.
        wr(5'd9, 1'b1);
        id_valid = 1'b1;
        id_ren   = 2'b01;
        id_raddr = {5'd0, 5'd9};
        @(negedge clk);
        chk("t6 stall before rst", 64'(stall), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 stall in rst", 64'(stall), 64'd0);
        chk("t6 wb_wen in rst", 64'(wb_wen), 64'd0);
        chk("t6 rdata0 in rst", rdata[63:0], 64'd0);
        chk("t6 fwd_hit in rst", 64'(fwd_hit), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        id_valid = 1'b0;
        id_ren   = '0;
        cyc();
        rd("t6", 2'b11, 5'd9, 5'd3, 64'd0, 64'd0, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
